// File: rtl/temp_pkg.sv
// Shared types and constants for the raw-temperature to BCD converter.
package temp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

  localparam int unsigned TEMP_LSB_SHIFT = 3;
  localparam logic [15:0] BCD_SATURATE   = 16'h1999;

endpackage

// File: rtl/bcd_add3_shift.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift {scratch, bin} left by one.
module bcd_add3_shift #(
  parameter int unsigned BinBits = 8
) (
  input  logic [11:0]        scratch_i,
  input  logic [BinBits-1:0] bin_i,
  output logic [11:0]        scratch_o,
  output logic [BinBits-1:0] bin_o
);

  logic [11:0] adj;

  always_comb begin
    adj = scratch_i;
    for (int i = 0; i < 3; i++) begin
      if (scratch_i[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_i[4*i +: 4] + 4'd3;
      end
    end
    {scratch_o, bin_o} = {adj, bin_i} << 1;
  end

endmodule

// File: rtl/temp_raw_to_bcd.sv
// Converts a 13-bit two's-complement sensor temperature into signed, saturated BCD
// {hundreds, tens, units, tenths} through a start/ready/done sequential double-dabble engine.
module temp_raw_to_bcd
  import temp_pkg::*;
#(
  parameter int unsigned INT_BITS = 8,
  parameter int unsigned MAX_INT  = 199
) (
  input  logic        Clock_100MHz,
  input  logic        Clear_n,
  input  logic [15:0] Temp_raw,
  input  logic        Start,
  output logic        Ready,
  output logic        Done,
  output logic [15:0] Bcd_out,
  output logic        Negative,
  output logic        Overrange
);

  localparam int unsigned CntW = $clog2(INT_BITS + 1);

  state_e              state_q, state_d;
  logic [12:0]         code_q, code_d;
  logic                sign_q, sign_d;
  logic                ovr_q, ovr_d;
  logic [3:0]          tenths_q, tenths_d;
  logic [11:0]         scratch_q, scratch_d;
  logic [INT_BITS-1:0] bin_q, bin_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [15:0]         bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic                ovr_out_q, ovr_out_d;
  logic                done_q, done_d;

  logic [12:0]         mag;
  logic [8:0]          int_part;
  logic [7:0]          frac_x10;
  logic [11:0]         scratch_nxt;
  logic [INT_BITS-1:0] bin_nxt;
  logic [15:0]         result;
  logic                unused_bits;

  bcd_add3_shift #(
    .BinBits (INT_BITS)
  ) u_step (
    .scratch_i (scratch_q),
    .bin_i     (bin_q),
    .scratch_o (scratch_nxt),
    .bin_o     (bin_nxt)
  );

  // 13-bit magnitude: code -4096 negates to 4096, which still fits unsigned.
  assign mag      = code_q[12] ? (~code_q + 13'd1) : code_q;
  assign int_part = mag[12:4];
  assign frac_x10 = {4'b0000, mag[3:0]} * 8'd10;
  assign result   = ovr_q ? BCD_SATURATE : {scratch_nxt, tenths_q};

  assign unused_bits = ^{Temp_raw[2:0], frac_x10[3:0]};

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    sign_d    = sign_q;
    ovr_d     = ovr_q;
    tenths_d  = tenths_q;
    scratch_d = scratch_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    ovr_out_d = ovr_out_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          code_d  = Temp_raw[15:TEMP_LSB_SHIFT];
          state_d = StLoad;
        end
      end
      StLoad: begin
        sign_d    = code_q[12];
        ovr_d     = 32'(int_part) > MAX_INT;
        tenths_d  = frac_x10[7:4];
        bin_d     = int_part[INT_BITS-1:0];
        scratch_d = 12'h000;
        cnt_d     = '0;
        state_d   = StShift;
      end
      StShift: begin
        scratch_d = scratch_nxt;
        bin_d     = bin_nxt;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntW'(INT_BITS - 1)) begin
          // Final shift: publish the result on the edge that enters StDone.
          bcd_d     = result;
          neg_d     = sign_q & (result != 16'h0000);
          ovr_out_d = ovr_q;
          done_d    = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q   <= StIdle;
      code_q    <= '0;
      sign_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tenths_q  <= '0;
      scratch_q <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovr_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      sign_q    <= sign_d;
      ovr_q     <= ovr_d;
      tenths_q  <= tenths_d;
      scratch_q <= scratch_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ovr_out_q <= ovr_out_d;
      done_q    <= done_d;
    end
  end

  assign Ready     = (state_q == StIdle);
  assign Done      = done_q;
  assign Bcd_out   = bcd_q;
  assign Negative  = neg_q;
  assign Overrange = ovr_out_q;

endmodule

// File: tb/tb_temp_raw_to_bcd.sv
// Directed bench for temp_raw_to_bcd: handshake timing, signed/saturated results, reset abort.
module tb_temp_raw_to_bcd;

  logic        clk;
  logic        clear_n;
  logic [15:0] temp_raw;
  logic        start;
  logic        ready;
  logic        done;
  logic [15:0] bcd_out;
  logic        negative;
  logic        overrange;

  int checks = 0;
  int errors = 0;

  temp_raw_to_bcd dut (
    .Clock_100MHz (clk),
    .Clear_n      (clear_n),
    .Temp_raw     (temp_raw),
    .Start        (start),
    .Ready        (ready),
    .Done         (done),
    .Bcd_out      (bcd_out),
    .Negative     (negative),
    .Overrange    (overrange)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: {ovr, negative, bcd}.
  function automatic logic [17:0] model(input logic [15:0] raw);
    logic [31:0] ext;
    int          v, m, ip, fr, tn;
    logic [15:0] bcd;
    logic        ovr;
    ext = {{19{raw[15]}}, raw[15:3]};
    v   = $signed(ext);
    m   = (v < 0) ? -v : v;
    ip  = m / 16;
    fr  = m % 16;
    tn  = (fr * 10) / 16;
    ovr = (ip > 199);
    if (ovr) bcd = 16'h1999;
    else bcd = {4'(ip / 100), 4'((ip / 10) % 10), 4'(ip % 10), 4'(tn)};
    return {ovr, (v < 0) && (bcd != 16'h0000), bcd};
  endfunction

  task automatic convert(input logic [15:0] raw, input logic [15:0] exp_bcd,
                         input logic exp_neg, input logic exp_ovr, input string tag);
    int    cyc;
    string t;
    t = $sformatf("%s_%h", tag, raw);
    @(negedge clk);
    temp_raw = raw;
    start    = 1'b1;
    @(posedge clk);
    #1;
    cyc   = 1;
    start = 1'b0;
    while (!done && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({t, "_latency"}, cyc, 10);
    chk({t, "_bcd"}, bcd_out, exp_bcd);
    chk({t, "_neg"}, negative, exp_neg);
    chk({t, "_ovr"}, overrange, exp_ovr);
    @(posedge clk);
    #1;
    chk({t, "_ready_after"}, {ready, done}, 2'b10);
  endtask

  initial begin
    logic [17:0] m;
    logic [15:0] raw;
    logic [15:0] got;
    int          dn, dcyc, nd;
    int          dt[3];

    clear_n  = 1'b0;
    start    = 1'b0;
    temp_raw = 16'h0000;
    #12;
    chk("reset_outputs", {ready, done, negative, overrange, bcd_out}, {4'b1000, 16'h0000});
    @(negedge clk);
    clear_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_start", {ready, done, bcd_out}, {2'b10, 16'h0000});

    convert(16'h0C80, 16'h0250, 1'b0, 1'b0, "p25_0");
    convert(16'hFAC0, 16'h0105, 1'b1, 1'b0, "m10_5");
    convert(16'h0CF8, 16'h0259, 1'b0, 1'b0, "p25_9375");
    convert(16'h4B00, 16'h1500, 1'b0, 1'b0, "p150");
    convert(16'h7FF8, 16'h1999, 1'b0, 1'b1, "p255_9375");
    convert(16'hFFF8, 16'h0000, 1'b0, 1'b0, "neg_zero");
    convert(16'h63F8, 16'h1999, 1'b0, 1'b0, "p199_9375");
    convert(16'h6400, 16'h1999, 1'b0, 1'b1, "p200");
    convert(16'h8000, 16'h1999, 1'b1, 1'b1, "m256");
    convert(16'h0008, 16'h0000, 1'b0, 1'b0, "p0_0625");

    // Start re-pulsed mid-conversion with a different word must be ignored.
    @(negedge clk);
    temp_raw = 16'h0C80;
    start    = 1'b1;
    dn = 0; dcyc = 0; got = 16'h0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dn++;
        dcyc = c;
        got  = bcd_out;
      end
      start = (c == 3 || c == 7);
      if (c == 3 || c == 7) temp_raw = 16'h4B00;
    end
    chk("ignored_start_done_count", dn, 1);
    chk("ignored_start_done_cycle", dcyc, 10);
    chk("ignored_start_value", got, 16'h0250);

    // Start held high: back-to-back conversions.
    @(negedge clk);
    temp_raw = 16'h0C80;
    start    = 1'b1;
    nd = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done && nd < 3) begin
        dt[nd] = c;
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", nd, 3);
    chk("b2b_period_1", dt[1] - dt[0], 11);
    chk("b2b_period_2", dt[2] - dt[1], 11);
    repeat (15) @(posedge clk);
    #1;
    chk("b2b_drained_ready", ready, 1'b1);

    // Asynchronous clear in the middle of SHIFT.
    convert(16'hFAC0, 16'h0105, 1'b1, 1'b0, "pre_clear");
    @(negedge clk);
    temp_raw = 16'h4B00;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_conv_busy", ready, 1'b0);
    clear_n = 1'b0;
    #1;
    chk("clear_outputs", {ready, done, negative, overrange, bcd_out}, {4'b1000, 16'h0000});
    @(negedge clk);
    clear_n = 1'b1;
    dn = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("clear_no_done", dn, 0);
    chk("clear_bcd_held_zero", bcd_out, 16'h0000);
    convert(16'h0CF8, 16'h0259, 1'b0, 1'b0, "post_clear");

    // Sweep a stride of the code space plus the extremes against the model.
    for (int i = 0; i < 8192; i += 3) begin
      raw = {i[12:0], 3'b000};
      m   = model(raw);
      convert(raw, m[15:0], m[16], m[17], "sweep");
    end
    raw = 16'h7FF8; m = model(raw); convert(raw, m[15:0], m[16], m[17], "sweep");
    raw = 16'h8000; m = model(raw); convert(raw, m[15:0], m[16], m[17], "sweep");
    raw = 16'hFFF8; m = model(raw); convert(raw, m[15:0], m[16], m[17], "sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
